// File: rtl/game_key_pkg.sv
// Shared definitions for the PS/2 key encoder and the player blocks.
// The phase codes, one-hot key codes and scan codes all live here.
package game_key_pkg;

   typedef enum logic [1:0] {
      PH_IDLE    = 2'b00,
      PH_POSEDGE = 2'b01,
      PH_HOLD    = 2'b11,
      PH_NEGEDGE = 2'b10
   } phase_t;

   typedef enum logic [1:0] {
      DEC_IDLE,
      DEC_EXT,
      DEC_BRK,
      DEC_EXTBRK
   } dec_state_t;

   localparam logic [4:0] KEY_NONE = 5'b00000;
   localparam logic [4:0] KEY_FWD  = 5'b10000;
   localparam logic [4:0] KEY_BACK = 5'b01000;
   localparam logic [4:0] KEY_UP   = 5'b00100;
   localparam logic [4:0] KEY_DOWN = 5'b00010;
   localparam logic [4:0] KEY_FIRE = 5'b00001;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;

   typedef struct packed {
      logic       p1;
      logic       p2;
      logic [4:0] key;
   } key_map_t;

   // Unmapped codes return no player and KEY_NONE.
   function automatic key_map_t map_scan(input logic ext, input logic [7:0] code);
      key_map_t m;
      m = '0;
      if (!ext) begin
         case (code)
            SC_D:     begin m.p1 = 1'b1; m.key = KEY_FWD;  end
            SC_A:     begin m.p1 = 1'b1; m.key = KEY_BACK; end
            SC_W:     begin m.p1 = 1'b1; m.key = KEY_UP;   end
            SC_S:     begin m.p1 = 1'b1; m.key = KEY_DOWN; end
            SC_SPACE: begin m.p1 = 1'b1; m.key = KEY_FIRE; end
            SC_ENTER: begin m.p2 = 1'b1; m.key = KEY_FIRE; end
            default:  m = '0;
         endcase
      end else begin
         case (code)
            SC_RIGHT: begin m.p2 = 1'b1; m.key = KEY_FWD;  end
            SC_LEFT:  begin m.p2 = 1'b1; m.key = KEY_BACK; end
            SC_UP:    begin m.p2 = 1'b1; m.key = KEY_UP;   end
            SC_DOWN:  begin m.p2 = 1'b1; m.key = KEY_DOWN; end
            default:  m = '0;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizer, clock glitch filter, frame shifter, timeout.
// Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FILTER_LEN     = 4
) (
   input  logic       clock,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]    clk_sync, dat_sync;
   logic          filt_clk;
   logic [FW-1:0] filt_cnt;
   logic [3:0]    bit_cnt;
   logic [7:0]    shift;
   logic [TW-1:0] to_cnt;
   logic          fall;
   logic          frame_ok;
`ifdef PS2_PARITY_CHECK_EN
   logic          parity_bit;
`endif

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         filt_clk <= 1'b1;
         filt_cnt <= FW'(FILTER_LEN - 1);
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_data};
         if (clk_sync[1] == filt_clk)
            filt_cnt <= FW'(FILTER_LEN - 1);
         else if (filt_cnt == '0)
            filt_clk <= clk_sync[1];
         else
            filt_cnt <= filt_cnt - 1'b1;
      end
   end

   // The filtered level flips on this cycle; treat that as the sampling edge.
   assign fall      = (filt_cnt == '0) && filt_clk && !clk_sync[1];
   assign byte_data = shift;

   always_comb begin
      frame_ok = dat_sync[1];
`ifdef PS2_PARITY_CHECK_EN
      frame_ok = frame_ok && (^{shift, parity_bit});
`endif
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         bit_cnt    <= 4'd0;
         shift      <= 8'h00;
         to_cnt     <= TW'(TIMEOUT_CYCLES - 1);
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (bit_cnt == 4'd0 || fall)
            to_cnt <= TW'(TIMEOUT_CYCLES - 1);
         else if (to_cnt != '0)
            to_cnt <= to_cnt - 1'b1;

         if (fall) begin
            if (bit_cnt == 4'd0) begin
               if (!dat_sync[1]) bit_cnt <= 4'd1;
            end else if (bit_cnt <= 4'd8) begin
               shift   <= {dat_sync[1], shift[7:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end else if (bit_cnt == 4'd9) begin
`ifdef PS2_PARITY_CHECK_EN
               parity_bit <= dat_sync[1];
`endif
               bit_cnt <= 4'd10;
            end else begin
               bit_cnt <= 4'd0;
               if (frame_ok) byte_valid <= 1'b1;
               else          frame_err  <= 1'b1;
            end
         end else if (bit_cnt != 4'd0 && to_cnt == '0) begin
            bit_cnt   <= 4'd0;
            frame_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 scan-code decoder driving one {phase,key} command bus per player.
// PS2_PARITY_CHECK_EN (passed to ps2_rx) enables parity rejection.
//
// decoder  | meaning
// DEC_IDLE   | waiting for a make code or prefix
// DEC_EXT    | E0 seen
// DEC_BRK    | F0 seen
// DEC_EXTBRK | E0 F0 seen
//
// channel    | meaning
// PH_IDLE    | no active key, bus 00
// PH_POSEDGE | press cycle of the latched key
// PH_HOLD    | key held, repeats ignored
// PH_NEGEDGE | release cycle, then idle
import game_key_pkg::*;

module ps2_key_encoder #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FILTER_LEN     = 4
) (
   input  logic       clock,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [6:0] key_p1,
   output logic [6:0] key_p2,
   output logic       frame_err
);
   logic       byte_valid;
   logic [7:0] byte_data;
   dec_state_t dec_state, dec_next;
   logic       ev_make, ev_brk, ev_ext;
   key_map_t   map;
   logic [1:0] ch_hit;
   phase_t     ch_state    [2];
   phase_t     ch_next     [2];
   logic [4:0] ch_key      [2];
   logic [4:0] ch_key_next [2];

   ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .FILTER_LEN(FILTER_LEN)) u_rx (
      .clock      (clock),
      .rst_n      (rst_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_err  (frame_err)
   );

   always_ff @(posedge clock) begin
      if (!rst_n) dec_state <= DEC_IDLE;
      else        dec_state <= dec_next;
   end

   always_comb begin
      dec_next = dec_state;
      ev_make  = 1'b0;
      ev_brk   = 1'b0;
      ev_ext   = 1'b0;
      if (byte_valid) begin
         case (dec_state)
            DEC_IDLE: begin
               if (byte_data == SC_EXT)      dec_next = DEC_EXT;
               else if (byte_data == SC_BRK) dec_next = DEC_BRK;
               else                          ev_make  = 1'b1;
            end
            DEC_EXT: begin
               if (byte_data == SC_BRK) dec_next = DEC_EXTBRK;
               else begin
                  ev_make  = 1'b1;
                  ev_ext   = 1'b1;
                  dec_next = DEC_IDLE;
               end
            end
            DEC_BRK: begin
               ev_brk   = 1'b1;
               dec_next = DEC_IDLE;
            end
            default: begin
               ev_brk   = 1'b1;
               ev_ext   = 1'b1;
               dec_next = DEC_IDLE;
            end
         endcase
      end
   end

   // A scan code maps to at most one player, so only one channel can react per byte.
   assign map    = map_scan(ev_ext, byte_data);
   assign ch_hit = {map.p2, map.p1};

   always_ff @(posedge clock) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            ch_state[i] <= PH_IDLE;
            ch_key[i]   <= KEY_NONE;
         end else begin
            ch_state[i] <= ch_next[i];
            ch_key[i]   <= ch_key_next[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         ch_next[i]     = ch_state[i];
         ch_key_next[i] = ch_key[i];
         case (ch_state[i])
            PH_IDLE: begin
               if (ev_make && ch_hit[i]) begin
                  ch_next[i]     = PH_POSEDGE;
                  ch_key_next[i] = map.key;
               end
            end
            PH_POSEDGE:
               ch_next[i] = (ev_brk && ch_hit[i] && map.key == ch_key[i]) ? PH_NEGEDGE : PH_HOLD;
            PH_HOLD: begin
               if (ev_brk && ch_hit[i] && map.key == ch_key[i]) ch_next[i] = PH_NEGEDGE;
            end
            default: begin
               ch_next[i]     = PH_IDLE;
               ch_key_next[i] = KEY_NONE;
            end
         endcase
      end
   end

   assign key_p1 = {ch_state[0], ch_key[0]};
   assign key_p2 = {ch_state[1], ch_key[1]};

endmodule
